// File: rtl/cdb_master_if.sv
// CDB master bus: functional-unit writeback ports in, common data bus broadcast out.
// master = the CDB driver side; slave = the units and snooping consumers.
interface cdb_master_if #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 4,
  parameter int ID_W   = 4
) ();
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU-1:0]       fu_ready;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*ID_W-1:0]  fu_inst_id;
  logic [NUM_FU*32-1:0]    fu_wdata;
  logic                    cdb_wr;
  logic [TAG_W-1:0]        cdb_tag;
  logic [ID_W-1:0]         cdb_inst_id;
  logic [31:0]             cdb_wdata;

  modport master (
    input  fu_valid, fu_tag, fu_inst_id, fu_wdata,
    output fu_ready, cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata
  );

  modport slave (
    output fu_valid, fu_tag, fu_inst_id, fu_wdata,
    input  fu_ready, cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata
  );
endinterface

// File: rtl/cdb_master.sv
// Common data bus driver: per-unit skid FIFOs, round-robin pick, registered broadcast.
// Latency 2 cycles input-to-cdb_wr; units see ready from FIFO occupancy, the CDB itself never stalls.

// Generic circular FIFO with occupancy counter; clr empties it at the next edge.
// Latency 1 cycle push-to-head; push_rdy depends on registered count only.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         push_rdy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_rdy = (count_q < CW'(DEPTH));
  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign push_ok  = push_vld & push_rdy;
  assign pop_ok   = pop_vld & head_vld;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module cdb_master #(
  parameter int NUM_FU     = 3,
  parameter int TAG_W      = 4,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_master_if.master bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [ID_W-1:0]  inst_id;
    logic [31:0]      wdata;
  } result_t;

  localparam int RES_W = $bits(result_t);

  logic [NUM_FU-1:0] push_vld;
  logic [NUM_FU-1:0] pop_vld;
  logic [NUM_FU-1:0] fifo_rdy;
  logic [NUM_FU-1:0] head_vld;
  result_t           push_dat [NUM_FU];
  result_t           head_dat [NUM_FU];

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_wr_q, cdb_wr_d;
  result_t           cdb_res_q, cdb_res_d;

  genvar k;
  generate
    for (k = 0; k < NUM_FU; k++) begin : g_fu
      assign push_dat[k] = {bus.fu_tag[k*TAG_W +: TAG_W],
                            bus.fu_inst_id[k*ID_W +: ID_W],
                            bus.fu_wdata[k*32 +: 32]};
      // A transfer that lands in a flush cycle belongs to squashed work.
      assign push_vld[k] = bus.fu_valid[k] & fifo_rdy[k] & ~flush;

      cdb_fifo #(
        .W     (RES_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (push_vld[k]),
        .push_dat (push_dat[k]),
        .pop_vld  (pop_vld[k]),
        .head_dat (head_dat[k]),
        .head_vld (head_vld[k]),
        .push_rdy (fifo_rdy[k])
      );

      a_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
        bus.fu_valid[k] |-> (bus.fu_tag[k*TAG_W +: TAG_W] != '0));
    end
  endgenerate

  assign bus.fu_ready = fifo_rdy;

  // Search starts at rr_ptr and wraps; the first occupied FIFO wins.
  always_comb begin : arb
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    pop_vld   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_FU) begin
        cand = cand - NUM_FU;
      end
      if (!grant_vld && head_vld[PTR_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
    if (grant_vld && !flush) begin
      pop_vld[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    cdb_wr_d  = grant_vld & ~flush;
    cdb_res_d = cdb_res_q;
    if (cdb_wr_d) begin
      rr_ptr_d  = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      cdb_res_d = head_dat[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      cdb_wr_q  <= 1'b0;
      cdb_res_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_wr_q  <= cdb_wr_d;
      cdb_res_q <= cdb_res_d;
    end
  end

  assign bus.cdb_wr      = cdb_wr_q;
  assign bus.cdb_tag     = cdb_res_q.tag;
  assign bus.cdb_inst_id = cdb_res_q.inst_id;
  assign bus.cdb_wdata   = cdb_res_q.wdata;
endmodule

// File: tb/tb_cdb_master.sv
// Bench for cdb_master: directed scenarios plus randomized traffic against a queue-based model.
module tb_cdb_master;
  localparam int NUM_FU = 3;
  localparam int TAG_W  = 4;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [3:0]  tag;
    logic [3:0]  id;
    logic [31:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  cdb_master_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

  cdb_master #(
    .NUM_FU     (NUM_FU),
    .TAG_W      (TAG_W),
    .ID_W       (ID_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: one queue per unit, a round-robin start index, and the expected bus state.
  res_t              mq [NUM_FU][$];
  int                rr;
  logic              exp_wr;
  res_t              exp_res;
  bit                exp_dc;
  logic [NUM_FU-1:0] acc;

  function automatic logic [NUM_FU-1:0] model_rdy();
    logic [NUM_FU-1:0] r;
    for (int k = 0; k < NUM_FU; k++) r[k] = (mq[k].size() < DEPTH);
    return r;
  endfunction

  function automatic res_t rnd_res(int k, int lo);
    res_t r;
    r.tag  = 4'($urandom_range(15, lo));
    r.id   = 4'($urandom_range(15, 0));
    r.data = {8'(k), 24'($urandom)};
    return r;
  endfunction

  task automatic drive_res(int k, res_t r);
    bus.fu_valid[k]           = 1'b1;
    bus.fu_tag[k*TAG_W +: 4]  = r.tag;
    bus.fu_inst_id[k*ID_W +: 4] = r.id;
    bus.fu_wdata[k*32 +: 32]  = r.data;
  endtask

  task automatic drive(int k, logic [3:0] tag, logic [3:0] id, logic [31:0] data);
    res_t r;
    r.tag  = tag;
    r.id   = id;
    r.data = data;
    drive_res(k, r);
  endtask

  // Advance one clock and the model with it; acc reports which units the model accepted.
  task automatic tick();
    int                g;
    logic [NUM_FU-1:0] a;
    res_t              inp [NUM_FU];
    g = -1;
    for (int i = 0; i < NUM_FU; i++) begin
      int k;
      k = (rr + i) % NUM_FU;
      if (g < 0 && mq[k].size() > 0) g = k;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      a[k]   = bus.fu_valid[k] && (mq[k].size() < DEPTH) && !flush;
      inp[k] = {bus.fu_tag[k*TAG_W +: 4], bus.fu_inst_id[k*ID_W +: 4], bus.fu_wdata[k*32 +: 32]};
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NUM_FU; k++) mq[k].delete();
      rr = 0; exp_wr = 1'b0; exp_res = '0; exp_dc = 1'b0; a = '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_FU; k++) mq[k].delete();
      exp_wr = 1'b0; exp_dc = 1'b1;
    end else begin
      exp_wr = 1'b0;
      if (g >= 0) begin
        exp_res = mq[g].pop_front();
        exp_wr  = 1'b1;
        exp_dc  = 1'b0;
        rr      = (g + 1) % NUM_FU;
      end
      for (int k = 0; k < NUM_FU; k++) if (a[k]) mq[k].push_back(inp[k]);
    end
    acc = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.fu_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", bus.cdb_wr); end
    n_cmp++; if (bus.cdb_tag !== 4'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_inst_id !== 4'h0) begin n_err++; $display("FAIL reset_id: got %h want 0", bus.cdb_inst_id); end
    n_cmp++; if (bus.cdb_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.cdb_wdata); end
    n_cmp++; if (bus.fu_ready !== 3'b111) begin n_err++; $display("FAIL reset_ready: got %b want 111", bus.fu_ready); end
  endtask

  task automatic test_single();
    drive(0, 4'h3, 4'h7, 32'hDEADBEEF);
    tick();
    bus.fu_valid = '0;
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL single_c1_wr: got %b want 0", bus.cdb_wr); end
    tick();
    n_cmp++; if (bus.cdb_wr !== 1'b1) begin n_err++; $display("FAIL single_c2_wr: got %b want 1", bus.cdb_wr); end
    n_cmp++; if (bus.cdb_tag !== 4'h3) begin n_err++; $display("FAIL single_tag: got %h want 3", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_inst_id !== 4'h7) begin n_err++; $display("FAIL single_id: got %h want 7", bus.cdb_inst_id); end
    n_cmp++; if (bus.cdb_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata: got %h want deadbeef", bus.cdb_wdata); end
    tick();
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL single_c3_wr: got %b want 0", bus.cdb_wr); end
    n_cmp++; if (bus.cdb_tag !== 4'h3) begin n_err++; $display("FAIL single_hold_tag: got %h want 3", bus.cdb_tag); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < NUM_FU; k++) drive(k, 4'(k + 1), 4'(k), 32'(k));
    tick();
    bus.fu_valid = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      tick();
      n_cmp++; if (bus.cdb_wr !== 1'b1) begin n_err++; $display("FAIL simul_wr%0d: got %b want 1", i, bus.cdb_wr); end
      n_cmp++; if (bus.cdb_tag !== 4'(i + 1)) begin n_err++; $display("FAIL simul_tag%0d: got %h want %0d", i, bus.cdb_tag, i + 1); end
    end
    tick();
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL simul_end_wr: got %b want 0", bus.cdb_wr); end
    // Round-robin pointer is back at 0, so unit 0 beats unit 1.
    drive(1, 4'h5, 4'h1, 32'h1);
    drive(0, 4'h4, 4'h0, 32'h0);
    tick();
    bus.fu_valid = '0;
    tick();
    n_cmp++; if (bus.cdb_tag !== 4'h4) begin n_err++; $display("FAIL simul_rr0_first: got %h want 4", bus.cdb_tag); end
    tick();
    n_cmp++; if (bus.cdb_tag !== 4'h5) begin n_err++; $display("FAIL simul_rr0_second: got %h want 5", bus.cdb_tag); end
    tick();
  endtask

  task automatic test_full_fifo();
    int         u1_idx;
    bit         saw_block;
    logic [7:0] units [$];
    logic [3:0] u1_tags [$];
    do_reset();
    u1_idx = 0;
    saw_block = 1'b0;
    drive_res(0, rnd_res(0, 1));
    drive_res(2, rnd_res(2, 1));
    drive(1, 4'h4, 4'h0, {8'd1, 24'd0});
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus.fu_valid[1] && !bus.fu_ready[1]) saw_block = 1'b1;
      tick();
      for (int k = 0; k < NUM_FU; k++) begin
        if (acc[k]) begin
          if (k == 1) begin
            u1_idx++;
            if (u1_idx < 3) drive(1, 4'(4 + u1_idx), 4'(u1_idx), {8'd1, 24'(u1_idx)});
            else bus.fu_valid[1] = 1'b0;
          end else if (cyc < 12) begin
            drive_res(k, rnd_res(k, 1));
          end else begin
            bus.fu_valid[k] = 1'b0;
          end
        end
      end
      if (bus.cdb_wr === 1'b1) begin
        units.push_back(bus.cdb_wdata[31:24]);
        if (bus.cdb_wdata[31:24] == 8'd1) u1_tags.push_back(bus.cdb_tag);
      end
    end
    n_cmp++; if (saw_block !== 1'b1) begin n_err++; $display("FAIL full_block: got %b want 1", saw_block); end
    n_cmp++; if (u1_tags.size() != 3) begin n_err++; $display("FAIL full_u1_count: got %0d want 3", u1_tags.size()); end
    for (int i = 0; i < 3 && i < u1_tags.size(); i++) begin
      n_cmp++; if (u1_tags[i] !== 4'(4 + i)) begin n_err++; $display("FAIL full_u1_order%0d: got %h want %0d", i, u1_tags[i], 4 + i); end
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= units.size() || units[i] !== 8'(i % 3)) begin
        n_err++; $display("FAIL full_rotation%0d: got %0d want %0d", i, (i < units.size()) ? int'(units[i]) : -1, i % 3);
      end
    end
  endtask

  task automatic test_fairness();
    int         drops;
    int         u1_seen;
    logic [7:0] units [$];
    do_reset();
    drive_res(1, rnd_res(1, 1));
    tick();
    bus.fu_valid = '0;
    tick();
    drops = 0;
    u1_seen = 0;
    drive_res(0, rnd_res(0, 1));
    drive_res(2, rnd_res(2, 1));
    for (int cyc = 0; cyc < 14; cyc++) begin
      tick();
      for (int k = 0; k < NUM_FU; k += 2) if (acc[k]) drive_res(k, rnd_res(k, 1));
      if (cyc >= 1) begin
        if (bus.cdb_wr !== 1'b1) drops++;
        else begin
          units.push_back(bus.cdb_wdata[31:24]);
          if (bus.cdb_wdata[31:24] == 8'd1) u1_seen++;
        end
      end
    end
    bus.fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= units.size() || units[i] !== ((i % 2 == 0) ? 8'd2 : 8'd0)) begin
        n_err++; $display("FAIL fair_order%0d: got %0d want %0d", i, (i < units.size()) ? int'(units[i]) : -1, (i % 2 == 0) ? 2 : 0);
      end
    end
    n_cmp++; if (drops != 0) begin n_err++; $display("FAIL fair_no_gap: got %0d gaps want 0", drops); end
    n_cmp++; if (u1_seen != 0) begin n_err++; $display("FAIL fair_no_u1: got %0d want 0", u1_seen); end
    repeat (6) tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < NUM_FU; k++) drive_res(k, rnd_res(k, 8));
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      for (int k = 0; k < NUM_FU; k++) if (acc[k]) drive_res(k, rnd_res(k, 8));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.fu_valid = '0;
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL flush_wr: got %b want 0", bus.cdb_wr); end
    n_cmp++; if (bus.fu_ready !== 3'b111) begin n_err++; $display("FAIL flush_ready: got %b want 111", bus.fu_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL flush_stale%0d: got wr %b tag %h want wr 0", i, bus.cdb_wr, bus.cdb_tag); end
    end
    drive(2, 4'hA, 4'h2, 32'h0A0A0A0A);
    tick();
    bus.fu_valid = '0;
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL flush_new_c1: got %b want 0", bus.cdb_wr); end
    tick();
    n_cmp++; if (bus.cdb_wr !== 1'b1) begin n_err++; $display("FAIL flush_new_wr: got %b want 1", bus.cdb_wr); end
    n_cmp++; if (bus.cdb_tag !== 4'hA) begin n_err++; $display("FAIL flush_new_tag: got %h want a", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_wdata !== 32'h0A0A0A0A) begin n_err++; $display("FAIL flush_new_wdata: got %h want 0a0a0a0a", bus.cdb_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < NUM_FU; k++) drive_res(k, rnd_res(k, 1));
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      for (int k = 0; k < NUM_FU; k++) if (acc[k]) drive_res(k, rnd_res(k, 1));
    end
    n_cmp++; if (bus.cdb_wr !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", bus.cdb_wr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.fu_valid = '0;
    n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL rstmid_wr: got %b want 0", bus.cdb_wr); end
    n_cmp++; if (bus.cdb_tag !== 4'h0) begin n_err++; $display("FAIL rstmid_tag: got %h want 0", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_inst_id !== 4'h0) begin n_err++; $display("FAIL rstmid_id: got %h want 0", bus.cdb_inst_id); end
    n_cmp++; if (bus.cdb_wdata !== 32'h0) begin n_err++; $display("FAIL rstmid_wdata: got %h want 0", bus.cdb_wdata); end
    n_cmp++; if (bus.fu_ready !== 3'b111) begin n_err++; $display("FAIL rstmid_ready: got %b want 111", bus.fu_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.cdb_wr !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet%0d: got %b want 0", i, bus.cdb_wr); end
    end
    drive(1, 4'h9, 4'h1, 32'h1);
    drive(0, 4'h7, 4'h0, 32'h0);
    tick();
    bus.fu_valid = '0;
    tick();
    n_cmp++; if (bus.cdb_tag !== 4'h7) begin n_err++; $display("FAIL rstmid_rr_first: got %h want 7", bus.cdb_tag); end
    tick();
    n_cmp++; if (bus.cdb_tag !== 4'h9) begin n_err++; $display("FAIL rstmid_rr_second: got %h want 9", bus.cdb_tag); end
    tick();
  endtask

  task automatic test_random();
    logic [NUM_FU-1:0] rdy;
    logic [NUM_FU-1:0] xfer;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy = model_rdy();
      n_cmp++; if (bus.fu_ready !== rdy) begin n_err++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.fu_ready, rdy); end
      flush = ($urandom_range(31, 0) == 0);
      xfer = bus.fu_valid & rdy;
      tick();
      flush = 1'b0;
      n_cmp++; if (bus.cdb_wr !== exp_wr) begin n_err++; $display("FAIL rand_wr@%0d: got %b want %b", cyc, bus.cdb_wr, exp_wr); end
      if (!exp_dc) begin
        n_cmp++;
        if ({bus.cdb_tag, bus.cdb_inst_id, bus.cdb_wdata} !== exp_res) begin
          n_err++; $display("FAIL rand_payload@%0d: got %h want %h", cyc, {bus.cdb_tag, bus.cdb_inst_id, bus.cdb_wdata}, exp_res);
        end
      end
      for (int k = 0; k < NUM_FU; k++) begin
        if (xfer[k] || !bus.fu_valid[k]) begin
          if ($urandom_range(1, 0) == 1) drive_res(k, rnd_res(k, 1));
          else bus.fu_valid[k] = 1'b0;
        end
      end
    end
    bus.fu_valid = '0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.fu_valid = '0;
    bus.fu_tag = '0;
    bus.fu_inst_id = '0;
    bus.fu_wdata = '0;
    rr = 0;
    exp_wr = 1'b0;
    exp_res = '0;
    exp_dc = 1'b0;
    acc = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_full_fifo();
    test_fairness();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
